// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial adder controller.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter wide enough to hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module fa_cell
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  // First half adder: operand bits.
  assign p  = a ^ b;
  assign g1 = a & b;

  // Second half adder: partial sum with carry-in.
  assign s  = p ^ ci;
  assign g2 = p & ci;

  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell stepped LSB first over WIDTH cycles.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   s_cat;
  logic [WIDTH-1:0] s_shift;

  // Single shared adder cell sees the current LSBs and the running carry.
  fa_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; safe for WIDTH=1.
  assign s_cat   = {fa_s, s_sh_q};
  assign s_shift = s_cat[WIDTH:1];

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          s_sh_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = s_shift;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake flags are decoded straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed cases, reset abort, random ops.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned W1    = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
    return W1'(x) + W1'(y) + W1'(c);
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return WIDTH'({$urandom(), $urandom()});
  endfunction

  // Wait for in_ready, present operands, and push the expected result on accept.
  task automatic accept_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xc);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    cin      = xc;
    @(posedge clk);
    exp_q.push_back(golden(xa, xb, xc));
  endtask

  // Run one operation end to end with garbage inputs during RUN and a chosen stall.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input int stall);
    int n = 0;
    logic [WIDTH:0] e;
    out_ready = (stall == 0);
    accept_op(xa, xb, xc);
    @(negedge clk);
    while (!out_valid && n < int'(WIDTH) + 4) begin
      if (n == 0) check("in_ready_run", 128'(in_ready), 128'(0));
      in_valid = 1'b1;
      a        = rand_word();
      b        = rand_word();
      cin      = 1'($urandom());
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", 128'(n), 128'(WIDTH));
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_result", 128'({cout, sum}), 128'(e));
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_busy", 128'(busy), 128'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 128'(1), 128'(0));
    end else begin
      e = exp_q.pop_front();
      check("result", 128'({cout, sum}), 128'(e));
    end
    @(negedge clk);
    check("valid_drop", 128'(out_valid), 128'(0));
    check("in_ready_back", 128'(in_ready), 128'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_result", 128'({cout, sum}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: carry ripple, alternating bits, carry-in only, backpressure.
    do_op(ones, WIDTH'(1), 1'b0, 0);
    do_op(WIDTH'(8'hA5), WIDTH'(8'h5A), 1'b1, 0);
    do_op('0, '0, 1'b1, 0);
    do_op(WIDTH'(8'h12), WIDTH'(8'h34), 1'b0, 5);

    // Asynchronous reset in the middle of an operation discards it.
    out_ready = 1'b0;
    accept_op(ones, ones, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_result", 128'({cout, sum}), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(1));
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(WIDTH'(8'h10), WIDTH'(8'h20), 1'b0, 0);

    // Random operations with random output stalls.
    for (int i = 0; i < 100; i++) begin
      do_op(rand_word(), rand_word(), 1'($urandom()), int'($urandom_range(0, 3)));
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
